// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: producer handshake and serial line of the buffered UART transmitter
interface uart_tx_buffered_if #(parameter int DBIT = 8);
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx;
    logic            tx_ready;
    logic            tx_busy;
    logic            tx_done_tick;
    logic            tx_overrun;
    modport master (output tx_start, din, input tx, tx_ready, tx_busy, tx_done_tick, tx_overrun);
    modport slave  (input tx_start, din, output tx, tx_ready, tx_busy, tx_done_tick, tx_overrun);
endinterface

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: UART transmitter with a one-byte holding register and gapless back-to-back frames
module uart_tx_buffered #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_s_tick,
    uart_tx_buffered_if.slave io_bus
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    logic [2:0]      r_state, w_state;
    logic [SW-1:0]   r_s, w_s;
    logic [NW-1:0]   r_n, w_n;
    logic [DBIT-1:0] r_b, w_b, r_hold;
    logic            r_p, w_p, r_hold_valid, r_tx, r_done, r_overrun;
    logic            w_load, w_done, w_tx, w_end16;
    assign w_end16 = i_s_tick && (r_s == SW'(15));
    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_n     = r_n;
        w_b     = r_b;
        w_p     = r_p;
        w_load  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE: w_load = r_hold_valid;
            START: begin
                if (i_s_tick) w_s = w_end16 ? '0 : r_s + 1'b1;
                if (w_end16) begin
                    w_n     = '0;
                    w_state = DATA;
                end
            end
            DATA: begin
                if (i_s_tick) w_s = w_end16 ? '0 : r_s + 1'b1;
                if (w_end16) begin
                    w_p = r_p ^ r_b[0];
                    w_b = r_b >> 1;
                    if (r_n == NW'(DBIT - 1)) w_state = (PARITY != 0) ? PAR : STOP;
                    else w_n = r_n + 1'b1;
                end
            end
            PAR: begin
                if (i_s_tick) w_s = w_end16 ? '0 : r_s + 1'b1;
                if (w_end16) w_state = STOP;
            end
            STOP: begin
                if (i_s_tick) begin
                    w_s = r_s + 1'b1;
                    if (r_s == SW'(SB_TICK - 1)) begin
                        w_s     = '0;
                        w_done  = 1'b1;
                        w_load  = r_hold_valid;
                        w_state = IDLE;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
        // a pending byte starts its frame immediately, from IDLE or straight out of STOP
        if (w_load) begin
            w_b     = r_hold;
            w_p     = (PARITY == 2);
            w_s     = '0;
            w_state = START;
        end
        w_tx = (w_state == START) ? 1'b0 : (w_state == DATA) ? w_b[0] : (w_state == PAR) ? w_p : 1'b1;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_s          <= '0;
            r_n          <= '0;
            r_b          <= '0;
            r_p          <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_tx         <= 1'b1;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_s       <= w_s;
            r_n       <= w_n;
            r_b       <= w_b;
            r_p       <= w_p;
            r_tx      <= w_tx;
            r_done    <= w_done;
            r_overrun <= io_bus.tx_start && r_hold_valid;
            if (io_bus.tx_start && !r_hold_valid) begin
                r_hold       <= io_bus.din;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
        end
    end
    assign io_bus.tx           = r_tx;
    assign io_bus.tx_ready     = !r_hold_valid;
    assign io_bus.tx_busy      = (r_state != IDLE);
    assign io_bus.tx_done_tick = r_done;
    assign io_bus.tx_overrun   = r_overrun;
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Serial UART transmitter that turns parallel bytes into asynchronous frames on `tx`, paced by the shared 16x oversampling tick from the baud-rate generator (19200 baud at 50 MHz). It is the sending end of the link whose receiver accepts frames on `rx` in the `Main` path. A one-entry holding register lets the producer queue the next byte while the current frame is still shifting out. Back-to-back frames are sent with no idle gap.

## Interface
- `DBIT`, 8, data bits per frame (LSB first)
- `SB_TICK`, 16, stop-bit duration in s_ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd

- `clk`  in  1  system clock (50 MHz)
- `reset`  in  1  synchronous, active-high reset
- `s_tick`  in  1  one-clk pulse at 16x baud, from the baud-rate generator
- `tx_start`  in  1  request to queue `din`; sampled each clk
- `din`  in  DBIT  byte to send; sampled when `tx_start && tx_ready`
- `tx`  out  1  serial line, registered, idle high
- `tx_ready`  out  1  holding register empty (`!hold_valid`)
- `tx_busy`  out  1  FSM not in IDLE
- `tx_done_tick`  out  1  one-clk pulse when a frame's stop bit completes
- `tx_overrun`  out  1  one-clk pulse when `tx_start` arrives while `tx_ready` = 0

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done_tick`=0, `tx_overrun`=0, state IDLE, tick counter 0, bit counter 0, holding register invalid.
- Accept: on an edge with `tx_start && tx_ready`, set `hold <= din` and `hold_valid <= 1`. If `tx_start` arrives while `!tx_ready`, drop the byte and pulse `tx_overrun`.
- Registers: tick counter `s` (4 bit, or wide enough for SB_TICK-1), bit counter `n` (clog2(DBIT)), shift register `b`, parity accumulator `p`.
- FSM states:
  - IDLE: `tx`=1. If `hold_valid`, load `b <= hold`, clear `hold_valid`, set `p` to 0 (even) or 1 (odd), clear `s`, and go to START. The load does not wait for `s_tick`.
  - START: `tx`=0. On each `s_tick`, increment `s`. On the tick where `s`==15, clear `s` and `n`, then go to DATA.
  - DATA: `tx`=`b[0]`. On the tick where `s`==15, set `p ^= b[0]` and shift `b` right. If `n`==DBIT-1, go to PARITY (PARITY≠0) or STOP; otherwise increment `n`.
  - PARITY: `tx`=`p`. Hold for 16 ticks, then go to STOP.
  - STOP: `tx`=1. On the tick where `s`==SB_TICK-1, pulse `tx_done_tick`. Then:
    - if `hold_valid`: load the next byte exactly as IDLE does and go straight to START;
    - otherwise go to IDLE.
- `tx` is driven from a register updated on the same edge as the state change, so it is glitch-free.
- Simultaneous events:
  - `tx_start` on the edge where IDLE/STOP moves `hold` into `b`: `tx_ready` is still 0, so the byte is dropped and `tx_overrun` pulses.
  - `tx_start` accepted in the same cycle as `tx_done_tick`: legal, because the holding register was already empty.
- Reset mid-frame: the frame is abandoned. `tx`=1 on the next edge, the holding register is cleared, no `tx_done_tick` is issued, and no runt stop bit is sent.
- `s_tick` ignored in IDLE; `din` changes while `!tx_ready` have no effect.

## Timing
- Latency: `tx_start` sampled at edge N sets `hold_valid` at N. The FSM leaves IDLE at N+1, and `tx` falls on that edge.
- Each start, data and parity bit lasts exactly 16 `s_tick` periods. Stop lasts SB_TICK periods.
- With tick divisor 163 at 50 MHz, one bit = 2608 clk = 52.16 µs.
- Frame length:
  - (1+DBIT+P)×16 + SB_TICK ticks, where P = 1 if PARITY≠0, else 0;
  - default = 160 ticks = 26080 clk.
- Back-to-back frames: the next start bit begins on the clk after the stop bit's final tick, with zero idle ticks.
- `tx_busy` is high from the START entry edge through the final STOP tick edge, and stays high across back-to-back frames.

## Test plan
- Reset held 5 clk, then released → `tx`=1, `tx_ready`=1, `tx_busy`=0, no pulses for 1000 clk; stray `s_tick` pulses in IDLE leave `tx` at 1.
- `din`=0x01, `tx_start` pulse → `tx` falls 1 clk later. Line sequence is 0 | 1,0,0,0,0,0,0,0 | 1, each bit 2608 clk. `tx_done_tick` fires once, 26080 clk after the fall.
- Queue 0x03, then 0x20 while the first frame is in DATA → second start bit immediately follows the first stop (no gap). Bits are 1,1,0,0,0,0,0,0 then 0,0,0,0,0,1,0,0. Two `tx_done_tick` pulses are seen.
- PARITY=1, `din`=0x07 → parity bit 1; PARITY=2, `din`=0x07 → parity bit 0. Frame is 176 ticks. A loopback receiver reports no framing error.
- With `hold_valid`=1 and a frame in flight, pulse `tx_start` with 0xAA → `tx_overrun` pulses 1 clk. 0xAA never appears on `tx`; the queued byte is still sent.
- Assert `reset` 1 clk during data bit 4 → `tx`=1 on the next edge, `tx_ready`=1, `tx_busy`=0, and no `tx_done_tick`. A subsequent 0x55 frame transmits correctly.
